// File: rtl/behave_mem_pkg.sv
// rtl/behave_mem_pkg.sv - shared constants and helpers for the srdy/drdy behavioural memory
package behave_mem_pkg;

  // Legal read latencies from request acceptance to data at the response buffer
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Request command encoding carried on c_write
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // Credit counter update selected each cycle
  typedef enum logic [1:0] {
    CR_HOLD = 2'd0,
    CR_INC  = 2'd1,
    CR_DEC  = 2'd2
  } credit_op_e;

  // Number of byte lanes in a word of the given bit width
  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/behave_rsp_fifo.sv
// rtl/behave_rsp_fifo.sv - register FIFO with srdy/drdy on both sides and a usage count
module behave_rsp_fifo #(
  parameter int depth  = 2,
  parameter int width  = 32,
  parameter int ptr_sz = (depth > 1) ? $clog2(depth) : 1,
  parameter int cnt_sz = $clog2(depth + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_srdy,
  output logic              c_drdy,
  input  logic [width-1:0]  c_data,
  output logic              p_srdy,
  input  logic              p_drdy,
  output logic [width-1:0]  p_data,
  output logic [cnt_sz-1:0] usage
);

  localparam logic [ptr_sz-1:0] LAST = ptr_sz'(depth - 1);
  localparam logic [cnt_sz-1:0] FULL = cnt_sz'(depth);

  logic [width-1:0]  store [depth];
  logic [ptr_sz-1:0] wr_ptr;
  logic [ptr_sz-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign c_drdy = (usage != FULL);
  assign p_srdy = (usage != '0);
  assign push   = c_srdy & c_drdy;
  assign pop    = p_srdy & p_drdy;
  // An empty buffer presents zero so the output is clean under reset
  assign p_data = p_srdy ? store[rd_ptr] : '0;

  function automatic logic [ptr_sz-1:0] next_ptr(input logic [ptr_sz-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; contents are dropped on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from usage
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= c_data;
  end

endmodule

// File: rtl/behave1p_mem_srdy.sv
// rtl/behave1p_mem_srdy.sv - single-port byte-writable RAM with srdy/drdy request and credited response
module behave1p_mem_srdy
  import behave_mem_pkg::*;
#(
  parameter int depth     = 256,
  parameter int width     = 32,
  parameter int be_sz     = bytes_of(width),
  parameter int addr_sz   = $clog2(depth),
  parameter int rd_lat    = 1,
  parameter int rsp_depth = rd_lat + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic               c_write,
  input  logic [addr_sz-1:0] c_addr,
  input  logic [be_sz-1:0]   c_be,
  input  logic [width-1:0]   c_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data
);

  localparam int              cnt_sz     = $clog2(rsp_depth + 1);
  localparam logic [cnt_sz-1:0] CREDIT_MAX = cnt_sz'(rsp_depth);

  if (rd_lat < RD_LAT_MIN || rd_lat > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("behave1p_mem_srdy: rd_lat must be 1 or 2");
  end
  if ((width % 8) != 0) begin : g_bad_width
    $error("behave1p_mem_srdy: width must be a multiple of 8");
  end

  logic [width-1:0]  mem [depth];
  logic [cnt_sz-1:0] credit;
  credit_op_e        credit_op;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              pop;
  logic [width-1:0]  rd_word;
  logic              push_srdy;
  logic [width-1:0]  push_data;
  logic              fifo_drdy;
  logic [cnt_sz-1:0] fifo_usage;
  logic [cnt_sz-1:0] in_flight;

  // A response leaving this cycle frees its credit immediately, so a full
  // memory can take a new request in the same cycle as the consumer drains one
  assign pop     = p_srdy & p_drdy;
  assign c_drdy  = (credit < CREDIT_MAX) | pop;
  assign acc     = c_srdy & c_drdy;
  assign wr_acc  = acc & (c_write == CMD_WR);
  assign rd_acc  = acc & (c_write == CMD_RD);
  assign rd_word = mem[c_addr];

  // Byte-enable merge into the addressed word; the array is never reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < be_sz; b++) begin
        if (c_be[b]) mem[c_addr][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  // Read data is captured at the acceptance edge, so a write in the previous
  // cycle is visible and later writes cannot disturb an accepted read
  if (rd_lat == 2) begin : g_lat2
    logic             pipe_v;
    logic [width-1:0] pipe_data;

    // Extra output register stage ahead of the response buffer
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipe_v    <= 1'b0;
        pipe_data <= '0;
      end else begin
        pipe_v <= rd_acc;
        if (rd_acc) pipe_data <= rd_word;
      end
    end

    assign push_srdy = pipe_v;
    assign push_data = pipe_data;
    assign in_flight = cnt_sz'(pipe_v);
  end else begin : g_lat1
    assign push_srdy = rd_acc;
    assign push_data = rd_word;
    assign in_flight = '0;
  end

  // Select the credit update: reads take one, delivered responses return one
  always_comb begin
    credit_op = CR_HOLD;
    if (rd_acc && !pop)      credit_op = CR_INC;
    else if (pop && !rd_acc) credit_op = CR_DEC;
  end

  // Credit counter tracks reads in flight plus buffered responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit <= '0;
    end else begin
      case (credit_op)
        CR_INC:  credit <= credit + 1'b1;
        CR_DEC:  credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  behave_rsp_fifo #(
    .depth (rsp_depth),
    .width (width)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .c_srdy  (push_srdy),
    .c_drdy  (fifo_drdy),
    .c_data  (push_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data),
    .usage   (fifo_usage)
  );

  // Simulation checks: credit bound and agreement with the actual occupancy
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (credit <= CREDIT_MAX);
      assert (credit == in_flight + fifo_usage);
      assert (!(push_srdy && !fifo_drdy));
    end
  end

  if (depth != (1 << addr_sz)) begin : g_addr_range
    // Addresses beyond the last word are a requester bug
    always_ff @(posedge clk) begin
      if (reset_n && acc) assert (int'(c_addr) < depth);
    end
  end

  // Per-word breakout for waveform viewing
  for (genvar i = 0; i < depth; i++) begin : g_dbg
    logic [width-1:0] word_unused;
    assign word_unused = mem[i];
  end

endmodule

// File: tb/tb_behave1p_mem_srdy.sv
// tb/tb_behave1p_mem_srdy.sv - directed self-checking bench for behave1p_mem_srdy with rd_lat=2
module tb_behave1p_mem_srdy;

  localparam int DEPTH  = 256;
  localparam int WIDTH  = 32;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_srdy;
  logic        c_drdy;
  logic        c_write;
  logic [7:0]  c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_data;
  logic        p_srdy;
  logic        p_drdy;
  logic [31:0] p_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [DEPTH];
  int          next_addr;
  int          stalls;
  int          last_cyc;
  logic        take;

  behave1p_mem_srdy #(
    .depth  (DEPTH),
    .width  (WIDTH),
    .rd_lat (RD_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_be    (c_be),
    .c_data  (c_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input string tag);
    c_srdy  = 1'b1;
    c_write = 1'b1;
    c_addr  = a;
    c_data  = d;
    c_be    = be;
    #1;
    chk({tag, "_wr_drdy"}, 32'(c_drdy), 32'd1);
    step();
    c_srdy  = 1'b0;
    c_write = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Reads base+pre .. base+n-1 with p_drdy=1 and expects data for base .. base+n-1 in order
  task automatic stream(input int base, input int pre, input int n, input string tag,
                        output int n_stall, output int last_rsp);
    int   sent;
    int   got;
    logic acc_now;
    sent     = pre;
    got      = 0;
    n_stall  = 0;
    last_rsp = -1;
    p_drdy   = 1'b1;
    for (int cyc = 0; cyc < n + 20 && got < n; cyc++) begin
      c_srdy  = (sent < n);
      c_write = 1'b0;
      c_addr  = 8'(base + sent);
      #1;
      if (c_srdy && !c_drdy) n_stall++;
      acc_now = c_srdy && c_drdy;
      if (p_srdy) begin
        chk($sformatf("%s_data%0d", tag, got), p_data, model[8'(base + got)]);
        got++;
        last_rsp = cyc;
      end
      step();
      if (acc_now) sent++;
    end
    c_srdy = 1'b0;
    chk({tag, "_rsp_count"}, 32'(got), 32'(n));
    repeat (3) begin
      #1;
      chk({tag, "_no_extra"}, 32'(p_srdy), 32'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    c_srdy  = 1'b0;
    c_write = 1'b0;
    c_addr  = '0;
    c_be    = '0;
    c_data  = '0;
    p_drdy  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("rst_p_data", p_data, 32'd0);
    chk("rst_c_drdy", 32'(c_drdy), 32'd1);
    reset_n = 1'b1;
    step();
    chk("post_rst_c_drdy", 32'(c_drdy), 32'd1);

    // Byte-enable merge and exact read latency
    do_write(8'd5, 32'hDEADBEEF, 4'hF, "t1a");
    do_write(8'd5, 32'h00001122, 4'b0011, "t1b");
    c_srdy = 1'b1; c_write = 1'b0; c_addr = 8'd5;
    #1;
    chk("t1_rd_drdy", 32'(c_drdy), 32'd1);
    step();
    c_srdy = 1'b0;
    #1;
    chk("t1_lat_cyc1", 32'(p_srdy), 32'd0);
    step();
    #1;
    chk("t1_lat_cyc2", 32'(p_srdy), 32'd1);
    chk("t1_data", p_data, 32'hDEAD1122);
    p_drdy = 1'b1;
    step();
    p_drdy = 1'b0;
    #1;
    chk("t1_drained", 32'(p_srdy), 32'd0);
    step();

    // Sustained one-per-cycle reads
    for (int i = 0; i < 64; i++) begin
      do_write(8'(i), 32'h0F000000 | (32'(i) << 8) | 32'(i), 4'hF, "t3w");
    end
    stream(0, 0, 64, "t3", stalls, last_cyc);
    chk("t3_stalls", 32'(stalls), 32'd0);
    chk("t3_last_cycle", 32'(last_cyc), 32'd65);

    // Credit limit under backpressure, then drain with no loss or duplication
    p_drdy    = 1'b0;
    next_addr = 0;
    for (int k = 0; k < 5; k++) begin
      c_srdy = 1'b1; c_write = 1'b0; c_addr = 8'(next_addr);
      #1;
      take = c_drdy;
      step();
      if (take) next_addr++;
    end
    chk("t2_accepted", 32'(next_addr), 32'd3);
    c_addr = 8'd3;
    #1;
    chk("t2_full_drdy", 32'(c_drdy), 32'd0);
    p_drdy = 1'b1;
    #1;
    chk("t2_comb_drdy", 32'(c_drdy), 32'd1);
    stream(0, 3, 5, "t2", stalls, last_cyc);
    chk("t2_stalls", 32'(stalls), 32'd0);

    // Last word, read in the very next cycle, and word 0 untouched
    do_write(8'd255, 32'hA5A5A5A5, 4'hF, "t4");
    stream(255, 0, 1, "t4_top", stalls, last_cyc);
    chk("t4_top_word", model[255], 32'hA5A5A5A5);
    stream(0, 0, 1, "t4_zero", stalls, last_cyc);

    // Zero byte-enable write is accepted and changes nothing
    do_write(8'd7, 32'h12345678, 4'hF, "t6a");
    p_drdy = 1'b0;
    do_write(8'd7, 32'hFFFFFFFF, 4'h0, "t6_be0");
    repeat (3) begin
      #1;
      chk("t6_no_rsp", 32'(p_srdy), 32'd0);
      step();
    end
    stream(7, 0, 1, "t6_rd", stalls, last_cyc);

    // Reset with responses pending
    p_drdy = 1'b0;
    c_srdy = 1'b1; c_write = 1'b0; c_addr = 8'd10;
    step();
    c_addr = 8'd11;
    step();
    c_srdy = 1'b0;
    step();
    step();
    #1;
    chk("t5_pending", 32'(p_srdy), 32'd1);
    reset_n = 1'b0;
    step();
    step();
    chk("t5_rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("t5_rst_p_data", p_data, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("t5_rel_c_drdy", 32'(c_drdy), 32'd1);
    chk("t5_rel_p_srdy", 32'(p_srdy), 32'd0);
    stream(20, 0, 2, "t5_fresh", stalls, last_cyc);
    chk("t5_first_cycle_accept", 32'(stalls), 32'd0);
    stream(10, 0, 2, "t5_keep", stalls, last_cyc);
    stream(5, 0, 1, "t5_keep5", stalls, last_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
